// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrant command issuer.
// Combinational helpers only, so there is no latency and no flow control here.
package quad_pkg;

  localparam int QUAD_N = 16;

  typedef enum logic [1:0] {IDLE, PEND, RUN, LOCK} quad_state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] idx;
  } onehot_t;

  // vld is set only when exactly one bit is high; idx then names that bit.
  function automatic onehot_t onehot16_to_idx(input logic [QUAD_N-1:0] bus);
    onehot_t    r;
    logic [4:0] cnt;
    r   = '0;
    cnt = '0;
    for (int i = 0; i < QUAD_N; i++) begin
      if (bus[i]) begin
        r.idx = 4'(i);
        cnt   = cnt + 5'd1;
      end
    end
    r.vld = (cnt == 5'd1);
    return r;
  endfunction

endpackage

// File: rtl/onehot_encoder16.sv
// 16-bit one-hot to 4-bit index encoder with a one-hot qualifier.
// Purely combinational, so it has zero latency and no backpressure.
module onehot_encoder16
  import quad_pkg::*;
(
  input  logic [QUAD_N-1:0] onehot,
  output logic [3:0]        idx,
  output logic              is_onehot
);

  onehot_t enc;

  assign enc       = onehot16_to_idx(onehot);
  assign idx       = enc.idx;
  assign is_onehot = enc.vld;

endmodule

// File: rtl/quadrant_cmd_issuer.sv
// Turns each key press into a quadrant command; cmd_valid rises 1 cycle after the press.
// cmd_valid holds until cmd_ready; presses are dropped while pending, running, or in post-done lockout.
module quadrant_cmd_issuer
  import quad_pkg::*;
#(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int ADDR_W  = 16,
  parameter int LOCKOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [QUAD_N-1:0] quad_confirm,
  input  logic              cmd_ready,
  input  logic              core_done,
  output logic              cmd_valid,
  output logic [3:0]        cmd_index,
  output logic [ADDR_W-1:0] cmd_base_addr,
  output logic              busy,
  output logic [QUAD_N-1:0] sel_led,
  output logic              err_multi
);

  localparam int unsigned ROW_STRIDE = (IMG_H / 4) * IMG_W;
  localparam int unsigned COL_STRIDE = IMG_W / 4;
  localparam int          CNT_W      = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
  localparam int          LOCK_LOAD  = (LOCKOUT > 0) ? LOCKOUT - 1 : 0;

  quad_state_t      state;
  logic [CNT_W-1:0] lock_cnt;
  logic             prev_any;
  logic             press;
  logic [3:0]       enc_idx;
  logic             enc_onehot;
  logic [31:0]      row_off;
  logic [31:0]      col_off;
  logic [31:0]      addr_full;

  onehot_encoder16 u_enc (
    .onehot    (quad_confirm),
    .idx       (enc_idx),
    .is_onehot (enc_onehot)
  );

  assign press = (|quad_confirm) && !prev_any;
  assign busy  = (state == PEND) || (state == RUN);

  // Strides are elaboration-time constants, so each offset is a 4-way constant mux.
  always_comb begin
    row_off = '0;
    col_off = '0;
    case (enc_idx[3:2])
      2'd1:    row_off = 32'(ROW_STRIDE);
      2'd2:    row_off = 32'(2 * ROW_STRIDE);
      2'd3:    row_off = 32'(3 * ROW_STRIDE);
      default: row_off = '0;
    endcase
    case (enc_idx[1:0])
      2'd1:    col_off = 32'(COL_STRIDE);
      2'd2:    col_off = 32'(2 * COL_STRIDE);
      2'd3:    col_off = 32'(3 * COL_STRIDE);
      default: col_off = '0;
    endcase
    addr_full = row_off + col_off;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lock_cnt      <= '0;
      prev_any      <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_index     <= '0;
      cmd_base_addr <= '0;
      sel_led       <= '0;
      err_multi     <= 1'b0;
    end else begin
      prev_any  <= |quad_confirm;
      err_multi <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            if (enc_onehot) begin
              cmd_index     <= enc_idx;
              cmd_base_addr <= ADDR_W'(addr_full);
              sel_led       <= quad_confirm;
              cmd_valid     <= 1'b1;
              state         <= PEND;
            end else begin
              err_multi <= 1'b1;
            end
          end
        end
        PEND: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (core_done) begin
            sel_led  <= '0;
            lock_cnt <= CNT_W'(LOCK_LOAD);
            state    <= (LOCKOUT == 0) ? IDLE : LOCK;
          end
        end
        LOCK: begin
          if (lock_cnt == '0) state <= IDLE;
          else                lock_cnt <= lock_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quadrant_cmd_issuer.sv
// Scoreboarded bench: a cycle-level reference model predicts commands and status,
// and an independent monitor compares the DUT after every rising edge.
module tb_quadrant_cmd_issuer;

  localparam int IMG_W   = 256;
  localparam int IMG_H   = 256;
  localparam int ADDR_W  = 16;
  localparam int LOCKOUT = 1000;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] quad_confirm;
  logic        cmd_ready;
  logic        core_done;
  logic        cmd_valid;
  logic [3:0]  cmd_index;
  logic [15:0] cmd_base_addr;
  logic        busy;
  logic [15:0] sel_led;
  logic        err_multi;

  int tests = 0;
  int fails = 0;
  int rise_cnt = 0;
  int err_cnt = 0;

  exp_t exp_q[$];

  // Reference model state: "pending"/"running" flags and a remaining-lockout count.
  bit          m_prev_any = 0;
  bit          m_pending = 0;
  bit          m_running = 0;
  int          m_lock_left = 0;
  logic [15:0] m_led = '0;
  bit          e_valid = 0;
  bit          e_busy = 0;
  bit          e_err = 0;
  logic [15:0] e_led = '0;

  quadrant_cmd_issuer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .LOCKOUT(LOCKOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .quad_confirm  (quad_confirm),
    .cmd_ready     (cmd_ready),
    .core_done     (core_done),
    .cmd_valid     (cmd_valid),
    .cmd_index     (cmd_index),
    .cmd_base_addr (cmd_base_addr),
    .busy          (busy),
    .sel_led       (sel_led),
    .err_multi     (err_multi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t expected_cmd(input logic [15:0] qc);
    exp_t e;
    int   k;
    int   a;
    k = 0;
    for (int i = 0; i < 16; i++) if (qc[i]) k = i;
    a = (k / 4) * (IMG_H / 4) * IMG_W + (k % 4) * (IMG_W / 4);
    e.idx  = 4'(k);
    e.addr = 16'(a);
    return e;
  endfunction

  // Predicts the DUT's state just after the coming rising edge.
  task automatic model_step();
    bit press;
    e_err = 0;
    if (rst) begin
      m_prev_any  = 0;
      m_pending   = 0;
      m_running   = 0;
      m_lock_left = 0;
      m_led       = '0;
    end else begin
      press      = (quad_confirm != 0) && !m_prev_any;
      m_prev_any = (quad_confirm != 0);
      if (m_pending) begin
        if (cmd_ready) begin
          m_pending = 0;
          m_running = 1;
        end
      end else if (m_running) begin
        if (core_done) begin
          m_running   = 0;
          m_led       = '0;
          m_lock_left = LOCKOUT;
        end
      end else if (m_lock_left > 0) begin
        m_lock_left--;
      end else if (press) begin
        if ($countones(quad_confirm) == 1) begin
          exp_q.push_back(expected_cmd(quad_confirm));
          m_pending = 1;
          m_led     = quad_confirm;
        end else begin
          e_err = 1;
        end
      end
    end
    e_valid = m_pending;
    e_busy  = m_pending || m_running;
    e_led   = m_led;
  endtask

  task automatic tick(input logic [15:0] qc, input logic rdy, input logic dn, input logic r);
    quad_confirm = qc;
    cmd_ready    = rdy;
    core_done    = dn;
    rst          = r;
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each cmd_valid rise.
  initial begin
    bit   prev_valid;
    exp_t e;
    prev_valid = 0;
    forever begin
      @(posedge clk);
      #1;
      check("cmd_valid", 32'(cmd_valid), 32'(e_valid));
      check("busy", 32'(busy), 32'(e_busy));
      check("sel_led", 32'(sel_led), 32'(e_led));
      check("err_multi", 32'(err_multi), 32'(e_err));
      if (err_multi === 1'b1) err_cnt++;
      if (cmd_valid === 1'b1 && !prev_valid) begin
        rise_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("cmd_index", 32'(cmd_index), 32'(e.idx));
          check("cmd_base_addr", 32'(cmd_base_addr), 32'(e.addr));
        end
      end
      prev_valid = (cmd_valid === 1'b1);
    end
  end

  initial begin
    int          r0;
    int          er0;
    logic [15:0] qc;
    int          k;

    // 1: reset
    for (int i = 0; i < 3; i++) tick(16'h0000, 1'b0, 1'b0, 1'b1);
    check("reset_index", 32'(cmd_index), 32'(0));
    check("reset_addr", 32'(cmd_base_addr), 32'(0));
    idle_ticks(2);

    // 2: level-held key gives one command, no ready
    r0 = rise_cnt;
    for (int i = 0; i < 249; i++) tick(16'h0020, 1'b0, 1'b0, 1'b0);
    check("held_key_rises", 32'(rise_cnt - r0), 32'(1));
    check("idx5", 32'(cmd_index), 32'(5));
    check("addr16448", 32'(cmd_base_addr), 32'(16448));
    check("led20", 32'(sel_led), 32'(16'h0020));

    // 3: handshake, then a press during RUN is ignored
    r0 = rise_cnt;
    tick(16'h0020, 1'b1, 1'b0, 1'b0);
    check("valid_drop", 32'(cmd_valid), 32'(0));
    idle_ticks(3);
    for (int i = 0; i < 3; i++) tick(16'h0001, 1'b0, 1'b0, 1'b0);
    idle_ticks(2);
    check("run_press_ignored", 32'(rise_cnt - r0), 32'(0));
    check("idx_retained", 32'(cmd_index), 32'(5));

    // 4: done, early press ignored, press after LOCKOUT+2 accepted
    tick(16'h0000, 1'b1, 1'b1, 1'b0);
    check("done_led_clear", 32'(sel_led), 32'(0));
    for (int i = 1; i <= LOCKOUT + 1; i++)
      tick((i == 10) ? 16'h0004 : 16'h0000, 1'b1, 1'b0, 1'b0);
    check("lock_press_ignored", 32'(rise_cnt - r0), 32'(0));
    for (int i = 0; i < 3; i++) tick(16'h0008, 1'b0, 1'b0, 1'b0);
    check("post_lock_accept", 32'(rise_cnt - r0), 32'(1));
    check("idx3", 32'(cmd_index), 32'(3));
    check("addr192", 32'(cmd_base_addr), 32'(192));
    tick(16'h0000, 1'b1, 1'b0, 1'b0);
    tick(16'h0000, 1'b0, 1'b1, 1'b0);
    idle_ticks(LOCKOUT + 2);

    // 5: multi-bit press
    r0  = rise_cnt;
    er0 = err_cnt;
    for (int i = 0; i < 3; i++) tick(16'h0003, 1'b1, 1'b0, 1'b0);
    idle_ticks(3);
    check("multi_err_pulses", 32'(err_cnt - er0), 32'(1));
    check("multi_no_cmd", 32'(rise_cnt - r0), 32'(0));
    check("multi_not_busy", 32'(busy), 32'(0));

    // 6: reset while pending, then index 15
    tick(16'h0010, 1'b0, 1'b0, 1'b0);
    tick(16'h0010, 1'b0, 1'b0, 1'b1);
    check("rst_drops_valid", 32'(cmd_valid), 32'(0));
    idle_ticks(2);
    tick(16'h8000, 1'b0, 1'b0, 1'b0);
    tick(16'h0000, 1'b0, 1'b0, 1'b0);
    check("idx15", 32'(cmd_index), 32'(15));
    check("addr49344", 32'(cmd_base_addr), 32'(49344));
    tick(16'h0000, 1'b1, 1'b0, 1'b0);
    tick(16'h0000, 1'b0, 1'b1, 1'b0);
    idle_ticks(LOCKOUT + 2);

    // Randomized traffic against the model
    qc = '0;
    for (int c = 0; c < 20000; c++) begin
      if ($urandom_range(3) == 0) begin
        k = $urandom_range(19);
        if (k < 10)      qc = 16'h0000;
        else if (k < 17) qc = 16'h0001 << $urandom_range(15);
        else             qc = 16'($urandom);
      end
      tick(qc, $urandom_range(2) == 0, $urandom_range(19) == 0, $urandom_range(999) == 0);
    end
    idle_ticks(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
